uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one uart transmit channel between NREQ requesters.
- Each requester presents bytes on a valid/ready interface, grouped into packets that end at a byte marked last.
- Grants are round-robin, and a grant is held for a whole packet so bytes from different requesters never interleave on tx.
- An idle-timeout releases a grant held by a requester that stalls mid-packet.
- Sits between the requester logic and the wr_en/din/wr_rdy side of uart; the rd side of uart is untouched.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 8, byte width; must match the uart din width.
- TIMEOUT, 1024, consecutive stalled cycles with the grant held before forced release (>=2).
- TW, 11, timeout counter width; must satisfy 2**TW > TIMEOUT.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  requester i has a byte on its data slice.
- req_data  in  NREQ*DW  byte of requester i at bits [i*DW +: DW].
- req_last  in  NREQ  byte of requester i is the last of its packet.
- req_ready  out  NREQ  byte of requester i is consumed this cycle.
- uart_wr_rdy  in  1  uart can accept a byte (uart wr_rdy).
- uart_wr_en  out  1  byte write strobe (to uart wr_en).
- uart_din  out  DW  byte to transmit (to uart din).
- grant  out  NREQ  one-hot current owner; all zero when idle.
- timeout_err  out  1  one-cycle pulse when a grant is force-released.

Behaviour:
- Reset (clk edge with rst=1): state=IDLE, grant=0, last-owner pointer=NREQ-1 (so requester 0 wins first), timeout counter=0. All outputs are 0 in the cycle after reset.
- Reset mid-packet: the grant drops immediately, nothing is transmitted, and no byte is consumed. The requester must restart its packet.
- A transfer happens in any cycle where uart_wr_en=1 and uart_wr_rdy=1.
- Outputs:
  - uart_wr_en = GRANTED & req_valid[g]
  - uart_din = req_data[g], or 0 when not GRANTED
  - req_ready[i] = GRANTED & (i==g) & uart_wr_rdy
  - all other req_ready bits are 0
- State IDLE:
  - If any req_valid is 1, pick the first valid index searching ptr+1, ptr+2, ... modulo NREQ.
  - Register it as g, set grant one-hot, go to GRANTED.
  - No transfer happens in IDLE, so arbitration latency is 1 cycle: valid at cycle N, earliest transfer at cycle N+1.
- State GRANTED:
  - Transfer with req_last[g]=1: next state IDLE, ptr<=g, grant<=0, counter<=0.
  - Transfer with req_last[g]=0: stay in GRANTED, counter<=0.
  - No transfer because req_valid[g]=0: counter increments. When counter reaches TIMEOUT-1 and the stall persists, go to IDLE, set ptr<=g, pulse timeout_err for 1 cycle, and clear the counter.
  - No transfer because uart_wr_rdy=0 while req_valid[g]=1: counter holds. Backpressure from the uart never causes a timeout.
- Packet back-to-back: after last, one IDLE cycle always follows. Maximum throughput is therefore one packet per (bytes + 1) cycles, provided the uart is ready.
- Fairness: a requester that just finished a packet is searched last. With all NREQ requesters valid, grants cycle 0,1,2,3,0,...
- Simultaneous requests in IDLE: only the round-robin winner is granted. The others stay pending with req_ready=0.
- Requests arriving while GRANTED are ignored until the return to IDLE.
- A single-byte packet (valid and last together) is legal: 1 arbitration cycle plus 1 transfer cycle.
- req_data of non-granted requesters and of a granted requester with valid=0 is don't-care and never reaches uart_din.

Decomposition:
- A shared package holds the state encoding (IDLE=1'b0, GRANTED=1'b1) and the default TIMEOUT constant.
- The natural sub-module is rr_pick: a combinational round-robin priority picker (req vector plus pointer in, one-hot winner and index out). It is reusable for a future rx demultiplexer.
- The FSM, counter and muxing stay in uart_tx_arbiter.

Test Plan:
- Single requester: reset, then req 1 sends 8'hE8 (last=1) with wr_rdy=1. Required: grant=4'b0010 one cycle after valid, then uart_wr_en=1 with uart_din=8'hE8 for exactly 1 cycle, req_ready[1] pulses once, and grant returns to 0.
- All four requesters valid with 2-byte packets (byte A[i]=8'h10+i, B[i]=8'h20+i). Required: uart_din sequence 10,20,11,21,12,22,13,23, each packet contiguous, grant order 0,1,2,3.
- Backpressure: hold wr_rdy=0 for 2000 cycles while req 2 is granted and valid. Required: no timeout_err, and req_ready stays 0. Release wr_rdy and the byte transfers.
- Stall: req 0 sends its first byte (last=0) and then drops valid. Required: timeout_err pulses once after TIMEOUT stalled cycles, grant goes to 0, then a pending req 1 is granted next.
- Reset mid-packet: assert rst while req 3 holds grant on byte 2 of 4. Required: grant=0, uart_wr_en=0 the next cycle, and the next grant goes to requester 0 when both 0 and 3 request.
- Loopback: connect tx to a second uart's rx with rd_en high. Required: received bytes match the submitted packet bytes in order.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg: shared state encoding, default sizes and index-width helper
package uart_tx_arbiter_pkg;
  typedef enum logic {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } state_t;
  localparam int NREQ_DEFAULT    = 4;
  localparam int DW_DEFAULT      = 8;
  localparam int TIMEOUT_DEFAULT = 1024;
  localparam int TW_DEFAULT      = 11;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, searches ptr+1, ptr+2, ... modulo N
module rr_pick import uart_tx_arbiter_pkg::*; #(
  parameter int N  = NREQ_DEFAULT,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic [IW-1:0] cand;
  // first set request after ptr in circular order wins; ptr itself is searched last
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    cand   = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!any && req[cand]) begin
        any          = 1'b1;
        idx          = cand;
        onehot[cand] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin packet arbiter sharing one uart tx channel between NREQ requesters
module uart_tx_arbiter import uart_tx_arbiter_pkg::*; #(
  parameter int NREQ    = NREQ_DEFAULT,
  parameter int DW      = DW_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int TW      = TW_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic [NREQ-1:0]    req_last,
  output logic [NREQ-1:0]    req_ready,
  input  logic               uart_wr_rdy,
  output logic               uart_wr_en,
  output logic [DW-1:0]      uart_din,
  output logic [NREQ-1:0]    grant,
  output logic               timeout_err
);
  localparam int IW = idx_w(NREQ);
  state_t          state_q, state_d;
  logic [IW-1:0]   g_q, g_d, ptr_q, ptr_d, pick_idx;
  logic [NREQ-1:0] grant_q, grant_d, pick_oh;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic            to_q, to_d, pick_any, act, xfer;
  logic [DW-1:0]   data_g;
  rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .req    (req_valid),
    .ptr    (ptr_q),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );
  assign act         = (state_q == GRANTED) && !rst;
  assign uart_wr_en  = act && req_valid[g_q];
  assign uart_din    = uart_wr_en ? data_g : '0;
  assign xfer        = uart_wr_en && uart_wr_rdy;
  assign grant       = grant_q;
  assign timeout_err = to_q;
  // owner's byte and ready strobe; rst gates them so a reset cycle never consumes a byte
  always_comb begin
    data_g    = '0;
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      data_g       = (g_q == IW'(i)) ? req_data[i*DW +: DW] : data_g;
      req_ready[i] = act && uart_wr_rdy && (g_q == IW'(i));
    end
  end
  // arbitration, packet hold and stall-timeout next-state
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    to_d    = 1'b0;
    if (state_q == IDLE) begin
      if (pick_any) begin
        state_d = GRANTED;
        g_d     = pick_idx;
        grant_d = pick_oh;
        cnt_d   = '0;
      end
    end else if (xfer) begin
      cnt_d = '0;
      if (req_last[g_q]) begin
        state_d = IDLE;
        ptr_d   = g_q;
        grant_d = '0;
      end
    end else if (!req_valid[g_q]) begin
      if (cnt_q == TW'(TIMEOUT - 1)) begin
        state_d = IDLE;
        ptr_d   = g_q;
        grant_d = '0;
        cnt_d   = '0;
        to_d    = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end
  // state registers; pointer resets to the last index so requester 0 wins first
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      g_q     <= '0;
      ptr_q   <= IW'(NREQ - 1);
      grant_q <= '0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized self-checking bench with a packet-level round-robin model
module tb_uart_tx_arbiter;
  localparam int NREQ = 4;
  localparam int DW = 8;
  localparam int TIMEOUT = 1024;
  localparam int TW = 11;
  logic clk = 1'b0;
  logic rst;
  logic [NREQ-1:0] req_valid, req_last, req_ready, grant;
  logic [NREQ*DW-1:0] req_data;
  logic uart_wr_rdy, uart_wr_en, timeout_err;
  logic [DW-1:0] uart_din;
  int checks = 0;
  int errors = 0;
  logic [8:0] pq[NREQ][$];
  logic [7:0] got_din[$];
  int got_own[$];
  int to_cnt, viol, last_xfer;

  uart_tx_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .uart_wr_rdy(uart_wr_rdy), .uart_wr_en(uart_wr_en),
    .uart_din(uart_din), .grant(grant), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    req_valid = '0;
    req_last = '0;
    req_data = '0;
    uart_wr_rdy = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drive(input int maxcyc, input int rdy_pct);
    int own;
    bit done;
    got_din.delete();
    got_own.delete();
    to_cnt = 0;
    viol = 0;
    last_xfer = -1;
    for (int c = 0; c < maxcyc; c++) begin
      @(negedge clk);
      uart_wr_rdy = ($urandom_range(99) < rdy_pct);
      for (int i = 0; i < NREQ; i++) begin
        req_valid[i] = pq[i].size() > 0;
        req_data[i*DW +: DW] = req_valid[i] ? pq[i][0][7:0] : DW'($urandom);
        req_last[i] = req_valid[i] ? pq[i][0][8] : 1'($urandom);
      end
      #1;
      if (timeout_err) to_cnt++;
      if (req_ready !== (uart_wr_rdy ? grant : '0) || uart_wr_en !== |(grant & req_valid)
          || (grant == '0 && uart_din !== '0)) viol++;
      if (uart_wr_en && uart_wr_rdy) begin
        own = -1;
        for (int i = 0; i < NREQ; i++) if (grant[i]) own = i;
        got_din.push_back(uart_din);
        got_own.push_back(own);
        last_xfer = c;
      end
      done = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i] && req_valid[i]) void'(pq[i].pop_front());
        if (pq[i].size() > 0) done = 1'b0;
      end
      if (done) break;
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    req_valid = '1;
    req_data = NREQ*DW'($urandom);
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++; if (grant !== '0) begin errors++; $display("FAIL reset_grant got %b exp 0", grant); end
    checks++; if (uart_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b exp 0", uart_wr_en); end
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_ready got %b exp 0", req_ready); end
    checks++; if (uart_din !== '0) begin errors++; $display("FAIL reset_din got %h exp 0", uart_din); end
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    #1;
    checks++; if (timeout_err !== 1'b0 || grant !== '0) begin errors++; $display("FAIL reset_after got to=%b grant=%b exp 0", timeout_err, grant); end
  endtask

  task automatic test_single();
    int en_cnt = 0;
    int rdy_cnt = 0;
    do_reset();
    @(negedge clk);
    req_valid = 4'b0010;
    req_data[1*DW +: DW] = 8'hE8;
    req_last = 4'b0010;
    #1;
    checks++; if (grant !== 4'b0000 || uart_wr_en !== 1'b0) begin errors++; $display("FAIL single_arb got grant=%b en=%b exp 0000 0", grant, uart_wr_en); end
    @(negedge clk);
    #1;
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL single_grant got %b exp 0010", grant); end
    checks++; if (uart_wr_en !== 1'b1 || uart_din !== 8'hE8) begin errors++; $display("FAIL single_xfer got en=%b din=%h exp 1 e8", uart_wr_en, uart_din); end
    for (int c = 0; c < 5; c++) begin
      if (uart_wr_en) en_cnt++;
      if (req_ready[1]) rdy_cnt++;
      @(negedge clk);
      req_valid = '0;
      #1;
    end
    checks++; if (en_cnt != 1 || rdy_cnt != 1) begin errors++; $display("FAIL single_once got en=%0d rdy=%0d exp 1 1", en_cnt, rdy_cnt); end
    checks++; if (grant !== '0) begin errors++; $display("FAIL single_release got %b exp 0000", grant); end
  endtask

  task automatic test_all_four();
    logic [7:0] exp_din[8];
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      pq[i].delete();
      pq[i].push_back({1'b0, 8'(8'h10 + i)});
      pq[i].push_back({1'b1, 8'(8'h20 + i)});
      exp_din[2*i] = 8'(8'h10 + i);
      exp_din[2*i+1] = 8'(8'h20 + i);
    end
    drive(60, 100);
    checks++; if (got_din.size() != 8) begin errors++; $display("FAIL four_count got %0d exp 8", got_din.size()); end
    for (int k = 0; k < 8 && k < got_din.size(); k++) begin
      checks++; if (got_din[k] !== exp_din[k] || got_own[k] != k / 2) begin errors++; $display("FAIL four_seq[%0d] got %h/%0d exp %h/%0d", k, got_din[k], got_own[k], exp_din[k], k / 2); end
    end
    checks++; if (last_xfer != 11) begin errors++; $display("FAIL four_throughput got last cycle %0d exp 11", last_xfer); end
    checks++; if (viol != 0 || to_cnt != 0) begin errors++; $display("FAIL four_protocol got viol=%0d to=%0d exp 0 0", viol, to_cnt); end
  endtask

  task automatic test_backpressure();
    int to_seen = 0;
    int rdy_seen = 0;
    int en_miss = 0;
    do_reset();
    @(negedge clk);
    req_valid = 4'b0100;
    req_data[2*DW +: DW] = 8'h5A;
    req_last = 4'b0100;
    uart_wr_rdy = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      #1;
      if (timeout_err) to_seen++;
      if (req_ready != '0) rdy_seen++;
      if (uart_wr_en !== 1'b1 || grant !== 4'b0100) en_miss++;
    end
    checks++; if (to_seen != 0) begin errors++; $display("FAIL bp_timeout got %0d pulses exp 0", to_seen); end
    checks++; if (rdy_seen != 0) begin errors++; $display("FAIL bp_ready got %0d ready cycles exp 0", rdy_seen); end
    checks++; if (en_miss != 0) begin errors++; $display("FAIL bp_hold got %0d bad cycles exp 0", en_miss); end
    @(negedge clk);
    uart_wr_rdy = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0100 || uart_din !== 8'h5A) begin errors++; $display("FAIL bp_release got rdy=%b din=%h exp 0100 5a", req_ready, uart_din); end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++; if (grant !== '0) begin errors++; $display("FAIL bp_done got %b exp 0000", grant); end
  endtask

  task automatic test_stall();
    int first_to = -1;
    int pulses = 0;
    logic [NREQ-1:0] g_before, g_at, g_after;
    logic en_after;
    logic [7:0] din_after;
    do_reset();
    @(negedge clk);
    req_valid = 4'b0011;
    req_data[0*DW +: DW] = 8'h33;
    req_data[1*DW +: DW] = 8'h44;
    req_last = 4'b0010;
    #1;
    @(negedge clk);
    #1;
    checks++; if (grant !== 4'b0001 || uart_din !== 8'h33) begin errors++; $display("FAIL stall_first got grant=%b din=%h exp 0001 33", grant, uart_din); end
    @(negedge clk);
    req_valid[0] = 1'b0;
    #1;
    for (int c = 1; c <= TIMEOUT + 1; c++) begin
      @(negedge clk);
      #1;
      if (timeout_err) begin
        pulses++;
        if (first_to < 0) first_to = c;
      end
      if (c == TIMEOUT - 1) g_before = grant;
      if (c == TIMEOUT) g_at = grant;
      if (c == TIMEOUT + 1) begin
        g_after = grant;
        en_after = uart_wr_en;
        din_after = uart_din;
      end
    end
    checks++; if (first_to != TIMEOUT || pulses != 1) begin errors++; $display("FAIL stall_timeout got first=%0d pulses=%0d exp %0d 1", first_to, pulses, TIMEOUT); end
    checks++; if (g_before !== 4'b0001 || g_at !== 4'b0000) begin errors++; $display("FAIL stall_release got %b,%b exp 0001,0000", g_before, g_at); end
    checks++; if (g_after !== 4'b0010 || en_after !== 1'b1 || din_after !== 8'h44) begin errors++; $display("FAIL stall_next got %b/%b/%h exp 0010/1/44", g_after, en_after, din_after); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    int b = 0;
    do_reset();
    @(negedge clk);
    req_valid = 4'b1000;
    req_data[3*DW +: DW] = 8'hA0;
    req_last = '0;
    #1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      req_data[3*DW +: DW] = 8'(8'hA0 + b);
      req_last[3] = (b == 3);
      #1;
      if (req_ready[3]) b++;
    end
    @(negedge clk);
    req_data[3*DW +: DW] = 8'(8'hA0 + b);
    rst = 1'b1;
    #1;
    checks++; if (b != 2 || uart_wr_en !== 1'b0 || req_ready !== '0) begin errors++; $display("FAIL rstmid_gate got b=%0d en=%b rdy=%b exp 2 0 0000", b, uart_wr_en, req_ready); end
    @(negedge clk);
    rst = 1'b0;
    req_valid = 4'b1001;
    #1;
    checks++; if (grant !== '0 || uart_wr_en !== 1'b0) begin errors++; $display("FAIL rstmid_drop got grant=%b en=%b exp 0000 0", grant, uart_wr_en); end
    @(negedge clk);
    #1;
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL rstmid_next got %b exp 0001", grant); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_random();
    logic [8:0] mq[NREQ][$];
    logic [8:0] e;
    logic [7:0] exp_din[$];
    int exp_own[$];
    int ptr, w, len, np, bad;
    for (int r = 0; r < 8; r++) begin
      do_reset();
      exp_din.delete();
      exp_own.delete();
      for (int i = 0; i < NREQ; i++) begin
        pq[i].delete();
        np = $urandom_range(3);
        for (int p = 0; p < np; p++) begin
          len = $urandom_range(1, 4);
          for (int k = 0; k < len; k++) pq[i].push_back({k == len - 1, 8'($urandom)});
        end
        mq[i] = pq[i];
      end
      ptr = NREQ - 1;
      while (1) begin
        w = -1;
        for (int k = 1; k <= NREQ; k++)
          if (w < 0 && mq[(ptr + k) % NREQ].size() > 0) w = (ptr + k) % NREQ;
        if (w < 0) break;
        do begin
          e = mq[w].pop_front();
          exp_din.push_back(e[7:0]);
          exp_own.push_back(w);
        end while (!e[8]);
        ptr = w;
      end
      drive(600, 60);
      checks++; if (got_din.size() != exp_din.size()) begin errors++; $display("FAIL rand%0d_count got %0d exp %0d", r, got_din.size(), exp_din.size()); end
      bad = -1;
      for (int k = 0; k < exp_din.size() && k < got_din.size(); k++)
        if (bad < 0 && (got_din[k] !== exp_din[k] || got_own[k] != exp_own[k])) bad = k;
      checks++; if (bad >= 0) begin errors++; $display("FAIL rand%0d_seq at %0d got %h/%0d exp %h/%0d", r, bad, got_din[bad], got_own[bad], exp_din[bad], exp_own[bad]); end
      checks++; if (viol != 0 || to_cnt != 0) begin errors++; $display("FAIL rand%0d_protocol got viol=%0d to=%0d exp 0 0", r, viol, to_cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_backpressure();
    test_stall();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
